serial_par_rx_n: RTL and testbench

SERIAL_PAR_RX_N -- requirements
Module: serial_par_rx_n

---
 rtl/phy_rx_pkg.sv | 16 +
 rtl/sp_lane.sv | 129 ++++++++++++
 rtl/serial_par_rx_n.sv | 37 +++
 tb/tb_serial_par_rx_n.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared lane state encoding and symbol constants
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ALIGNED = 2'd1,
        ST_ACTIVE  = 2'd2
    } lane_state_t;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
    localparam logic [7:0] IDLE_SYM      = COMMA_DEFAULT;
    // A run of these bytes means the far end has stopped driving the lane
    localparam logic [7:0] LOSS_SYM      = 8'hFF;
    localparam int         BYTE_BITS     = 8;

endpackage

// File: rtl/sp_lane.sv
// rtl/sp_lane.sv - one serial lane: comma search, byte framing, activity and loss tracking
module sp_lane
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA         = COMMA_DEFAULT,
    parameter int         ACTIVE_COMMAS = 4,
    parameter int         LOSS_BYTES    = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       lane_en,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       sync_err
);

    localparam int CW = $clog2(ACTIVE_COMMAS) + 1;
    localparam int FW = $clog2(LOSS_BYTES) + 1;
    localparam logic [CW-1:0] COMMA_TARGET = CW'(ACTIVE_COMMAS);
    localparam logic [FW-1:0] LOSS_TARGET  = FW'(LOSS_BYTES);
    localparam logic [2:0]    LAST_BIT     = 3'(BYTE_BITS - 1);

    lane_state_t   state;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] comma_cnt;
    logic [FW-1:0] ff_cnt;

    logic [7:0]    shifted;
    logic          boundary;
    logic          is_comma;
    logic          is_loss;
    logic [CW-1:0] comma_inc;
    logic [FW-1:0] ff_inc;

    // The byte under test always includes the bit arriving on this edge
    assign shifted   = {sr[6:0], data_in};
    assign boundary  = (bit_cnt == LAST_BIT);
    assign is_comma  = (shifted == COMMA);
    assign is_loss   = (shifted == LOSS_SYM);

    // Saturating increments: counters stick at all-ones instead of wrapping
    assign comma_inc = (&comma_cnt) ? comma_cnt : comma_cnt + CW'(1);
    assign ff_inc    = (&ff_cnt)    ? ff_cnt    : ff_cnt + FW'(1);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= ST_SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            ff_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sr        <= shifted;
            valid_out <= 1'b0;
            sync_err  <= 1'b0;
            if (!lane_en) begin
                state     <= ST_SEARCH;
                bit_cnt   <= '0;
                comma_cnt <= '0;
                ff_cnt    <= '0;
                active    <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
                unique case (state)
                    ST_SEARCH: begin
                        bit_cnt <= '0;
                        if (is_comma) begin
                            comma_cnt <= CW'(1);
                            ff_cnt    <= '0;
                            if (COMMA_TARGET <= CW'(1)) begin
                                state  <= ST_ACTIVE;
                                active <= 1'b1;
                            end else begin
                                state <= ST_ALIGNED;
                            end
                        end
                    end
                    ST_ALIGNED: begin
                        if (boundary) begin
                            if (is_comma) begin
                                comma_cnt <= comma_inc;
                                if (comma_inc >= COMMA_TARGET) begin
                                    state  <= ST_ACTIVE;
                                    active <= 1'b1;
                                end
                            end else begin
                                state     <= ST_SEARCH;
                                comma_cnt <= '0;
                                sync_err  <= 1'b1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (boundary) begin
                            if (is_comma) begin
                                ff_cnt <= '0;
                            end else if (is_loss && (ff_inc >= LOSS_TARGET)) begin
                                // The byte that completes the loss run is swallowed
                                state     <= ST_SEARCH;
                                active    <= 1'b0;
                                sync_err  <= 1'b1;
                                comma_cnt <= '0;
                                ff_cnt    <= '0;
                            end else begin
                                ff_cnt    <= is_loss ? ff_inc : '0;
                                data_out  <= shifted;
                                valid_out <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= ST_SEARCH;
                        comma_cnt <= '0;
                        ff_cnt    <= '0;
                        active    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/serial_par_rx_n.sv
// rtl/serial_par_rx_n.sv - multi-lane serial-to-parallel receiver, one independent sp_lane per lane
module serial_par_rx_n
    import phy_rx_pkg::*;
#(
    parameter int         LANES         = 2,
    parameter logic [7:0] COMMA         = COMMA_DEFAULT,
    parameter int         ACTIVE_COMMAS = 4,
    parameter int         LOSS_BYTES    = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic [LANES-1:0]     data_in,
    input  logic [LANES-1:0]     lane_en,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     valid_out,
    output logic [LANES-1:0]     active,
    output logic [LANES-1:0]     sync_err
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sp_lane #(
            .COMMA         (COMMA),
            .ACTIVE_COMMAS (ACTIVE_COMMAS),
            .LOSS_BYTES    (LOSS_BYTES)
        ) u_lane (
            .clk_32f   (clk_32f),
            .reset     (reset),
            .data_in   (data_in[i]),
            .lane_en   (lane_en[i]),
            .data_out  (data_out[8*i +: 8]),
            .valid_out (valid_out[i]),
            .active    (active[i]),
            .sync_err  (sync_err[i])
        );
    end

endmodule

// File: tb/tb_serial_par_rx_n.sv
// tb/tb_serial_par_rx_n.sv - self-checking bench for serial_par_rx_n against a byte-level stream model
module tb_serial_par_rx_n;

    localparam int         LANES         = 4;
    localparam int         MAXN          = 512;
    localparam logic [7:0] COMMA         = 8'hBC;
    localparam int         ACTIVE_COMMAS = 4;
    localparam int         LOSS_BYTES    = 4;

    logic               clk_32f = 1'b0;
    logic               reset;
    logic [LANES-1:0]   data_in;
    logic [LANES-1:0]   lane_en;
    logic [8*LANES-1:0] data_out;
    logic [LANES-1:0]   valid_out;
    logic [LANES-1:0]   active;
    logic [LANES-1:0]   sync_err;

    int checks = 0;
    int errors = 0;

    logic       stream  [LANES][MAXN];
    int         slen    [LANES];
    logic       exp_val [LANES][MAXN];
    logic       exp_act [LANES][MAXN];
    logic       exp_err [LANES][MAXN];
    logic [7:0] exp_dat [LANES][MAXN];
    logic       obs_val [LANES][MAXN];
    logic       obs_act [LANES][MAXN];
    logic       obs_err [LANES][MAXN];
    logic [7:0] obs_dat [LANES][MAXN];

    serial_par_rx_n #(
        .LANES         (LANES),
        .COMMA         (COMMA),
        .ACTIVE_COMMAS (ACTIVE_COMMAS),
        .LOSS_BYTES    (LOSS_BYTES)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .lane_en   (lane_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .sync_err  (sync_err)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic clear_streams();
        for (int l = 0; l < LANES; l++) begin
            slen[l] = 0;
            for (int e = 0; e < MAXN; e++) stream[l][e] = 1'b0;
        end
    endtask

    task automatic push_byte(input int l, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            stream[l][slen[l]] = b[k];
            slen[l]++;
        end
    endtask

    task automatic push_bits(input int l, input int k, input bit rnd);
        for (int i = 0; i < k; i++) begin
            stream[l][slen[l]] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            slen[l]++;
        end
    endtask

    function automatic int max_len();
        int m = 0;
        for (int l = 0; l < LANES; l++) if (slen[l] > m) m = slen[l];
        return m;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        data_in = '0;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_stream(input int n);
        for (int e = 0; e < n; e++) begin
            for (int l = 0; l < LANES; l++) data_in[l] = stream[l][e];
            @(posedge clk_32f);
            #1;
            for (int l = 0; l < LANES; l++) begin
                obs_val[l][e] = valid_out[l];
                obs_act[l][e] = active[l];
                obs_err[l][e] = sync_err[l];
                obs_dat[l][e] = data_out[8*l +: 8];
            end
        end
    endtask

    // Last eight bits seen by edge t; bits before the stream start are zero
    function automatic logic [7:0] win(input int l, input int t);
        logic [7:0] w = '0;
        for (int k = 7; k >= 0; k--) w = {w[6:0], (t - k >= 0) ? stream[l][t - k] : 1'b0};
        return w;
    endfunction

    // Walk the lane's bit stream byte by byte and mark, per edge, the expected outputs
    task automatic model_lane(input int l, input int n);
        int t, b, cnt, ff;
        logic [7:0] by, held;
        for (int e = 0; e < n; e++) begin
            exp_val[l][e] = 1'b0;
            exp_act[l][e] = 1'b0;
            exp_err[l][e] = 1'b0;
            exp_dat[l][e] = 8'h00;
        end
        t = 0;
        while (t < n) begin
            if (win(l, t) != COMMA) begin
                t++;
                continue;
            end
            cnt = 1;
            b   = t;
            while (cnt < ACTIVE_COMMAS && b + 8 < n) begin
                b += 8;
                if (win(l, b) == COMMA) cnt++;
                else break;
            end
            if (cnt < ACTIVE_COMMAS) begin
                if (b == t || win(l, b) == COMMA) break;
                exp_err[l][b] = 1'b1;
                t = b + 1;
                continue;
            end
            for (int e = b; e < n; e++) exp_act[l][e] = 1'b1;
            ff = 0;
            t  = n;
            while (b + 8 < n) begin
                b += 8;
                by = win(l, b);
                if (by == COMMA) begin
                    ff = 0;
                end else if (by == 8'hFF && ff + 1 >= LOSS_BYTES) begin
                    exp_err[l][b] = 1'b1;
                    for (int e = b; e < n; e++) exp_act[l][e] = 1'b0;
                    t = b + 1;
                    break;
                end else begin
                    ff = (by == 8'hFF) ? ff + 1 : 0;
                    exp_val[l][b] = 1'b1;
                    exp_dat[l][b] = by;
                end
            end
        end
        held = 8'h00;
        for (int e = 0; e < n; e++) begin
            if (exp_val[l][e]) held = exp_dat[l][e];
            exp_dat[l][e] = held;
        end
    endtask

    task automatic model_all(input int n);
        for (int l = 0; l < LANES; l++) model_lane(l, n);
    endtask

    task automatic test_reset();
        lane_en = '1;
        do_reset();
        checks++;
        if ({data_out, valid_out, active, sync_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got d%h v%b a%b e%b required all zero", data_out, valid_out, active, sync_err);
        end
    endtask

    task automatic test_align_lane0();
        int k, n, nval, first_act, first_val;
        clear_streams();
        lane_en = '1;
        do_reset();
        k = $urandom_range(0, 7);
        push_bits(0, k, 1'b0);
        repeat (4) push_byte(0, COMMA);
        push_byte(0, 8'hAA);
        repeat (2) push_byte(0, COMMA);
        n = max_len();
        run_stream(n);
        model_all(n);
        for (int e = 0; e < n; e++)
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                    {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                    errors++;
                    $display("FAIL align_stream lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                             l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                             exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                end
            end
        nval = 0; first_act = -1; first_val = -1;
        for (int e = 0; e < n; e++) begin
            if (obs_val[0][e]) begin nval++; if (first_val < 0) first_val = e; end
            if (obs_act[0][e] && first_act < 0) first_act = e;
        end
        checks++;
        if (nval != 1) begin errors++; $display("FAIL align_valid_count got %0d required 1", nval); end
        checks++;
        if (first_act != k + 31) begin errors++; $display("FAIL align_active_edge got %0d required %0d", first_act, k + 31); end
        checks++;
        if (first_val != k + 39) begin errors++; $display("FAIL align_valid_edge got %0d required %0d", first_val, k + 39); end
        checks++;
        if (obs_dat[0][n-1] !== 8'hAA) begin errors++; $display("FAIL align_data got %h required aa", obs_dat[0][n-1]); end
    endtask

    task automatic test_sync_err();
        int n, nerr, nact;
        clear_streams();
        lane_en = '1;
        do_reset();
        repeat (3) push_byte(1, COMMA);
        push_byte(1, 8'h55);
        repeat (2) push_byte(1, 8'h00);
        n = max_len();
        run_stream(n);
        model_all(n);
        for (int e = 0; e < n; e++)
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                    {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                    errors++;
                    $display("FAIL syncerr_stream lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                             l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                             exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                end
            end
        nerr = 0; nact = 0;
        for (int e = 0; e < n; e++) begin
            if (obs_err[1][e]) nerr++;
            if (obs_act[1][e]) nact++;
        end
        checks++;
        if (nerr != 1 || !obs_err[1][31]) begin
            errors++;
            $display("FAIL syncerr_pulse got count %0d at31 %b required count 1 at31 1", nerr, obs_err[1][31]);
        end
        checks++;
        if (nact != 0) begin errors++; $display("FAIL syncerr_active got %0d active cycles required 0", nact); end
    endtask

    task automatic test_loss();
        int n, nval, nerr;
        clear_streams();
        lane_en = '1;
        do_reset();
        repeat (4) push_byte(0, COMMA);
        repeat (4) push_byte(0, 8'hFF);
        repeat (2) push_byte(0, COMMA);
        n = max_len();
        run_stream(n);
        model_all(n);
        for (int e = 0; e < n; e++)
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                    {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                    errors++;
                    $display("FAIL loss_stream lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                             l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                             exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                end
            end
        nval = 0; nerr = 0;
        for (int e = 0; e < n; e++) begin
            if (obs_val[0][e]) nval++;
            if (obs_err[0][e]) nerr++;
        end
        checks++;
        if (nval != 3 || obs_val[0][63]) begin
            errors++;
            $display("FAIL loss_valid got count %0d at63 %b required count 3 at63 0", nval, obs_val[0][63]);
        end
        checks++;
        if (nerr != 1 || !obs_err[0][63]) begin
            errors++;
            $display("FAIL loss_syncerr got count %0d at63 %b required count 1 at63 1", nerr, obs_err[0][63]);
        end
        checks++;
        if (obs_act[0][62] !== 1'b1 || obs_act[0][63] !== 1'b0) begin
            errors++;
            $display("FAIL loss_active got e62 %b e63 %b required 1 0", obs_act[0][62], obs_act[0][63]);
        end
    endtask

    task automatic test_lane_offsets();
        logic [7:0] vals [LANES];
        int n;
        vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC; vals[3] = 8'hDD;
        clear_streams();
        lane_en = '1;
        do_reset();
        for (int l = 0; l < LANES; l++) begin
            push_bits(l, l, 1'b0);
            repeat (4) push_byte(l, COMMA);
            push_byte(l, vals[l]);
            repeat (2) push_byte(l, COMMA);
        end
        n = max_len();
        run_stream(n);
        model_all(n);
        for (int e = 0; e < n; e++)
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                    {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                    errors++;
                    $display("FAIL offset_stream lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                             l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                             exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                end
            end
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (obs_val[l][l + 39] !== 1'b1 || obs_dat[l][l + 39] !== vals[l]) begin
                errors++;
                $display("FAIL offset_delivery lane %0d got v%b d%h required v1 d%h",
                         l, obs_val[l][l + 39], obs_dat[l][l + 39], vals[l]);
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        int n, bad;
        clear_streams();
        lane_en = '1;
        do_reset();
        for (int l = 0; l < LANES; l += 2) begin
            repeat (4) push_byte(l, COMMA);
            push_byte(l, 8'h33);
            push_byte(l, 8'h5A);
        end
        n = 45;
        run_stream(n);
        model_all(n);
        for (int e = 0; e < n; e++)
            for (int l = 0; l < LANES; l++) begin
                checks++;
                if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                    {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                    errors++;
                    $display("FAIL midreset_stream lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                             l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                             exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                end
            end
        checks++;
        if (obs_dat[0][44] !== 8'h33 || obs_act[2][44] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_before got d%h a%b required d33 a1", obs_dat[0][44], obs_act[2][44]);
        end
        for (int l = 0; l < LANES; l++) data_in[l] = stream[l][45];
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        checks++;
        if ({data_out, valid_out, active, sync_err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got d%h v%b a%b e%b required all zero", data_out, valid_out, active, sync_err);
        end
        bad = 0;
        for (int e = 46; e < 64; e++) begin
            for (int l = 0; l < LANES; l++) data_in[l] = stream[l][e];
            @(posedge clk_32f);
            #1;
            if (valid_out != '0 || active != '0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_no_partial got %0d bad cycles required 0", bad); end
    endtask

    task automatic test_lane_enable();
        int n, bad;
        clear_streams();
        lane_en = 4'b1101;
        do_reset();
        for (int l = 0; l < LANES; l++) begin
            repeat (4) push_byte(l, COMMA);
            push_byte(l, 8'h3C);
            repeat (2) push_byte(l, COMMA);
        end
        n = max_len();
        run_stream(n);
        model_all(n);
        for (int e = 0; e < n; e++)
            for (int l = 0; l < LANES; l++) begin
                if (l == 1) continue;
                checks++;
                if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                    {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                    errors++;
                    $display("FAIL enable_stream lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                             l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                             exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                end
            end
        bad = 0;
        for (int e = 0; e < n; e++)
            if (obs_val[1][e] || obs_act[1][e] || obs_err[1][e] || obs_dat[1][e] != 8'h00) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL enable_lane1_idle got %0d busy cycles required 0", bad); end
        checks++;
        if (obs_act[0][n-1] !== 1'b1) begin errors++; $display("FAIL enable_lane0_active got %b required 1", obs_act[0][n-1]); end
        lane_en = '1;
    endtask

    task automatic test_random();
        int n, r;
        for (int it = 0; it < 6; it++) begin
            clear_streams();
            lane_en = '1;
            do_reset();
            for (int l = 0; l < LANES; l++) begin
                push_bits(l, $urandom_range(0, 15), 1'b1);
                repeat ($urandom_range(3, 4)) push_byte(l, COMMA);
                for (int b = 0; b < 12; b++) begin
                    r = $urandom_range(0, 9);
                    if (r < 3)      push_byte(l, COMMA);
                    else if (r < 6) push_byte(l, 8'hFF);
                    else            push_byte(l, 8'($urandom_range(0, 255)));
                end
            end
            n = max_len();
            run_stream(n);
            model_all(n);
            for (int e = 0; e < n; e++)
                for (int l = 0; l < LANES; l++) begin
                    checks++;
                    if ({obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e]} !==
                        {exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]}) begin
                        errors++;
                        $display("FAIL random_stream iter %0d lane %0d edge %0d got v%b a%b e%b d%h required v%b a%b e%b d%h",
                                 it, l, e, obs_val[l][e], obs_act[l][e], obs_err[l][e], obs_dat[l][e],
                                 exp_val[l][e], exp_act[l][e], exp_err[l][e], exp_dat[l][e]);
                    end
                end
        end
    endtask

    initial begin
        reset   = 1'b1;
        data_in = '0;
        lane_en = '1;
        test_reset();
        test_align_lane0();
        test_sync_err();
        test_loss();
        test_lane_offsets();
        test_reset_mid_byte();
        test_lane_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
